seg_scan: RTL and testbench

Time-multiplexed 8-digit seven-segment scan driver that sits directly downstream of the calculator's binary-to-LED converter. It takes the eight per-digit segment bytes plus the overflow flag, snapshots them once per frame, and drives one shared segment bus with a one-hot digit select. Dead-time blanking between digits suppresses ghosting. While overflow is set, an error pattern blinks on all digits.

---
 rtl/seg_scan_pkg.sv | 13 +
 rtl/seg_scan.sv | 139 +++++++++++++
 tb/tb_seg_scan.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [7:0] OVF_SEG_DEFAULT = 8'h79;

endpackage

// File: rtl/seg_scan.sv
// 8-digit time-multiplexed seven-segment driver: per-frame snapshot, dead-time
// blanking between digits, and a blinking error pattern while overflow is held.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_GAP = 8,
  parameter int BLINK_FRAMES = 64,
  parameter logic [7:0] OVF_SEG = OVF_SEG_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] led_low,
  input  logic [7:0] led_middle_1,
  input  logic [7:0] led_middle_2,
  input  logic [7:0] led_middle_3,
  input  logic [7:0] led_middle_4,
  input  logic [7:0] led_middle_5,
  input  logic [7:0] led_middle_6,
  input  logic [7:0] led_high,
  input  logic       overflow,
  input  logic       blank,
  output logic [7:0] seg,
  output logic [7:0] dig_sel,
  output logic       frame_start
);

  localparam int PH_MAX = (SCAN_DIV > BLANK_GAP) ? SCAN_DIV : BLANK_GAP;
  localparam int PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_GAP - 1);
  localparam logic [PH_W-1:0] SHOW_LAST = PH_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic              capture;
  logic [7:0]        led_in [NUM_DIGITS];
  logic [7:0]        snap [NUM_DIGITS];
  logic              snap_ovf;
  logic [FC_W-1:0]   frame_cnt;
  logic              blink_ph;

  function automatic logic [7:0] digit_seg(input logic [7:0] pattern,
                                           input logic       ovf,
                                           input logic       ph);
    if (ovf) return ph ? 8'h00 : OVF_SEG;
    return pattern;
  endfunction

  always_comb begin
    led_in[0] = led_low;
    led_in[1] = led_middle_1;
    led_in[2] = led_middle_2;
    led_in[3] = led_middle_3;
    led_in[4] = led_middle_4;
    led_in[5] = led_middle_5;
    led_in[6] = led_middle_6;
    led_in[7] = led_high;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase + PH_W'(1);
    // The opening dead-time cycle of digit 0 is the frame boundary.
    capture   = (state == BLANK) && (idx == '0) && (phase == '0);
    unique case (state)
      BLANK: begin
        if (phase == BLANK_LAST) begin
          state_nxt = SHOW;
          phase_nxt = '0;
        end
      end
      SHOW: begin
        if (phase == SHOW_LAST) begin
          state_nxt = BLANK;
          phase_nxt = '0;
          idx_nxt   = idx + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = BLANK;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= BLANK;
      idx   <= '0;
      phase <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      phase <= phase_nxt;
    end
  end

  // Frame snapshot and blink phase
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
      snap_ovf  <= 1'b0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= led_in[i];
      snap_ovf <= overflow;
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      seg         <= '0;
      dig_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= capture;
      if (blank || (state == BLANK)) begin
        seg     <= '0;
        dig_sel <= '0;
      end else begin
        seg     <= digit_seg(snap[idx], snap_ovf, blink_ph);
        dig_sel <= 8'd1 << idx;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomized bench for seg_scan against a frame-position arithmetic model.
module tb_seg_scan;

  localparam int SD = 4;
  localparam int BG = 2;
  localparam int BF = 2;
  localparam int SLOT = SD + BG;
  localparam int FRAME = 8 * SLOT;
  localparam logic [7:0] OVF_PAT = 8'h79;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] leds [8];
  logic       overflow = 1'b0;
  logic       blank = 1'b0;
  logic [7:0] seg;
  logic [7:0] dig_sel;
  logic       frame_start;

  int n_vec = 0;
  int n_err = 0;

  // Model state: n = edges since the first edge out of reset (-1 while in reset).
  int         n = -1;
  int         m_caps = 0;
  logic [7:0] m_snap [8];
  logic       m_ovf = 1'b0;

  always #5 sys_clk = ~sys_clk;

  seg_scan #(
    .SCAN_DIV(SD),
    .BLANK_GAP(BG),
    .BLINK_FRAMES(BF),
    .OVF_SEG(OVF_PAT)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .led_low(leds[0]),
    .led_middle_1(leds[1]),
    .led_middle_2(leds[2]),
    .led_middle_3(leds[3]),
    .led_middle_4(leds[4]),
    .led_middle_5(leds[5]),
    .led_middle_6(leds[6]),
    .led_high(leds[7]),
    .overflow(overflow),
    .blank(blank),
    .seg(seg),
    .dig_sel(dig_sel),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at n=%0d t=%0t: got %h, expected %h", tag, n, $time, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e_seg, e_dig;
    logic       e_fs;
    int         pos, d, off, ph;
    logic       rst_s, blank_s;
    @(posedge sys_clk);
    rst_s   = rst;
    blank_s = blank;
    e_seg = 8'h00;
    e_dig = 8'h00;
    e_fs  = 1'b0;
    if (rst_s) begin
      n = -1;
      m_caps = 0;
      m_ovf = 1'b0;
      for (int i = 0; i < 8; i++) m_snap[i] = 8'h00;
    end else begin
      n++;
      pos = n % FRAME;
      if (pos == 0) begin
        for (int i = 0; i < 8; i++) m_snap[i] = leds[i];
        m_ovf = overflow;
        m_caps++;
      end
      e_fs = (pos == 0);
      d   = pos / SLOT;
      off = pos % SLOT;
      ph  = (m_caps / BF) % 2;
      if (!blank_s && off >= BG) begin
        e_dig = 8'(1 << d);
        e_seg = m_ovf ? ((ph != 0) ? 8'h00 : OVF_PAT) : m_snap[d];
      end
    end
    #1;
    check("dig_sel", 32'(dig_sel), 32'(e_dig));
    check("seg", 32'(seg), 32'(e_seg));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("onehot", 32'($countones(dig_sel) <= 1), 32'd1);
    check("dark_seg", 32'((dig_sel != 8'h00) || (seg == 8'h00)), 32'd1);
  endtask

  initial begin
    int blank_left = 0;
    int rst_left = 0;
    bit did_rst = 1'b0;
    leds[0] = 8'h3F; leds[1] = 8'h5B; leds[2] = 8'h4F; leds[3] = 8'h5B;
    leds[4] = 8'h66; leds[5] = 8'h6D; leds[6] = 8'h7D; leds[7] = 8'h06;
    for (int cyc = 0; cyc < 1150; cyc++) begin
      // reset at start, then once more while digit 4 is lit
      if (cyc < 3) rst = 1'b1;
      else if (!did_rst && n == 10 * FRAME + 4 * SLOT + 3) begin
        did_rst = 1'b1;
        rst_left = 2;
      end
      if (cyc >= 3) begin
        rst = (rst_left > 0);
        if (rst_left > 0) rst_left--;
      end
      if (cyc == 6) leds[3] = 8'h4F;
      if (cyc >= 3 + 2 * FRAME && cyc < 3 + 7 * FRAME) overflow = 1'b1;
      else if (cyc > 12 * FRAME) overflow = 1'($urandom_range(0, 1));
      else overflow = 1'b0;
      if (cyc > 7 * FRAME && $urandom_range(0, 15) == 0)
        leds[$urandom_range(0, 7)] = 8'($urandom);
      if (cyc == 3 + 8 * FRAME + 10) blank_left = 10;
      else if (cyc > 12 * FRAME && blank_left == 0 && $urandom_range(0, 60) == 0)
        blank_left = $urandom_range(1, 12);
      blank = (blank_left > 0);
      if (blank_left > 0) blank_left--;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
